// File: rtl/bk_pkg.sv
// Shared types and cell functions for the Brent-Kung prefix adder.
package bk_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  localparam int unsigned BK_WIDTH  = 16;
  localparam int unsigned BK_LEVELS = $clog2(BK_WIDTH);

  function automatic gp_t bk_black(gp_t hi, gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  // A completed prefix includes bit -1 (p = 0), so its group propagate is 0.
  function automatic gp_t bk_gray(gp_t hi, gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/bk_black_cell.sv
// Brent-Kung black cell: combines a (G,P) pair with its lower neighbour.
module bk_black_cell
  import bk_pkg::*;
(
  input  gp_t i_hi,
  input  gp_t i_lo,
  output gp_t o_gp
);

  assign o_gp = bk_black(i_hi, i_lo);

endmodule

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder with valid/ready stages S0 and S2.
// Define BK_ADDER_MID_REG_EN to insert stage S1 between up-sweep and down-sweep.
module bk_adder_pipe
  import bk_pkg::*;
#(
  parameter int unsigned WIDTH = BK_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int unsigned LEVELS = $clog2(WIDTH);
`ifdef BK_ADDER_MID_REG_EN
  localparam int unsigned NUM_STAGES = 3;
`else
  localparam int unsigned NUM_STAGES = 2;
`endif

  logic [NUM_STAGES-1:0] w_valid;
  logic [NUM_STAGES-1:0] w_valid_in;
  logic [NUM_STAGES-1:0] w_load;
  logic [NUM_STAGES:0]   w_ready;

  logic [WIDTH-1:0] r_a, r_b;
  logic             r_cin;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic [WIDTH-1:0] w_g, w_p;
  logic [WIDTH-1:0] w_p_sum;
  logic             w_cin_sum;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  gp_t w_up [LEVELS+1][WIDTH];
  gp_t w_dn [LEVELS][WIDTH];

`ifdef BK_ADDER_MID_REG_EN
  gp_t              r_gp_mid [WIDTH];
  logic [WIDTH-1:0] r_p_mid;
  logic             r_cin_mid;
`endif

  // Ready ripples back from the consumer; in_valid never enters this chain.
  always_comb begin
    w_ready             = '0;
    w_ready[NUM_STAGES] = out_ready;
    for (int k = int'(NUM_STAGES) - 1; k >= 0; k--) begin
      w_ready[k] = !w_valid[k] || w_ready[k+1];
    end
  end

  assign w_valid_in = {w_valid[NUM_STAGES-2:0], in_valid};
  assign w_load     = w_valid_in & w_ready[NUM_STAGES-1:0];

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic r_stage_valid;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_stage_valid <= 1'b0;
      end else if (w_ready[k]) begin
        r_stage_valid <= w_valid_in[k];
      end
    end

    assign w_valid[k] = r_stage_valid;

    if (k == 0) begin : g_s0
      always_ff @(posedge clk) begin
        if (rst) begin
          r_a   <= '0;
          r_b   <= '0;
          r_cin <= 1'b0;
        end else if (w_load[k]) begin
          r_a   <= in_a;
          r_b   <= in_b;
          r_cin <= in_cin;
        end
      end
    end else if (k == NUM_STAGES - 1) begin : g_s2
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sum  <= '0;
          r_cout <= 1'b0;
        end else if (w_load[k]) begin
          r_sum  <= w_sum;
          r_cout <= w_cout;
        end
      end
    end
`ifdef BK_ADDER_MID_REG_EN
    else begin : g_s1
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < int'(WIDTH); i++) r_gp_mid[i] <= '0;
          r_p_mid   <= '0;
          r_cin_mid <= 1'b0;
        end else if (w_load[k]) begin
          for (int i = 0; i < int'(WIDTH); i++) r_gp_mid[i] <= w_up[LEVELS][i];
          r_p_mid   <= w_p;
          r_cin_mid <= r_cin;
        end
      end
    end
`endif
  end

  assign w_g = r_a & r_b;
  assign w_p = r_a ^ r_b;

  // Carry-in folded into bit 0 as the (cin, 0) pair at position -1.
  assign w_up[0][0] = bk_black(gp_t'({w_g[0], w_p[0]}), gp_t'({r_cin, 1'b0}));
  for (genvar i = 1; i < WIDTH; i++) begin : g_leaf
    assign w_up[0][i] = gp_t'({w_g[i], w_p[i]});
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_up
    localparam int unsigned STEP = 1 << l;
    localparam int unsigned HALF = 1 << (l - 1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (((i + 1) % STEP) == 0) begin : g_cell
        if (i == STEP - 1) begin : g_gray
          assign w_up[l][i] = bk_gray(w_up[l-1][i], w_up[l-1][i-HALF]);
        end else begin : g_black
          bk_black_cell u_black (
            .i_hi (w_up[l-1][i]),
            .i_lo (w_up[l-1][i-HALF]),
            .o_gp (w_up[l][i])
          );
        end
      end else begin : g_pass
        assign w_up[l][i] = w_up[l-1][i];
      end
    end
  end

`ifdef BK_ADDER_MID_REG_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_dn_src
    assign w_dn[0][i] = r_gp_mid[i];
  end
  assign w_p_sum   = r_p_mid;
  assign w_cin_sum = r_cin_mid;
`else
  for (genvar i = 0; i < WIDTH; i++) begin : g_dn_src
    assign w_dn[0][i] = w_up[LEVELS][i];
  end
  assign w_p_sum   = w_p;
  assign w_cin_sum = r_cin;
`endif

  // Down-sweep fills the odd-offset positions left incomplete by the up-sweep.
  for (genvar s = 1; s < LEVELS; s++) begin : g_dn
    localparam int unsigned LVL  = LEVELS - s;
    localparam int unsigned STEP = 1 << LVL;
    localparam int unsigned HALF = 1 << (LVL - 1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if ((((i + 1) % STEP) == HALF) && (i >= STEP)) begin : g_gray
        assign w_dn[s][i] = bk_gray(w_dn[s-1][i], w_dn[s-1][i-HALF]);
      end else begin : g_pass
        assign w_dn[s][i] = w_dn[s-1][i];
      end
    end
  end

  assign w_sum[0] = w_p_sum[0] ^ w_cin_sum;
  for (genvar i = 1; i < WIDTH; i++) begin : g_sum
    assign w_sum[i] = w_p_sum[i] ^ w_dn[LEVELS-1][i-1].g;
  end
  assign w_cout = w_dn[LEVELS-1][WIDTH-1].g;

  assign in_ready  = w_ready[0];
  assign out_valid = w_valid[NUM_STAGES-1];
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Self-checking bench for bk_adder_pipe: directed table, handshake corners, random stream.
module tb_bk_adder_pipe;

  localparam int W = 16;
`ifdef BK_ADDER_MID_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;

  bk_adder_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int step_no = 0;

  logic [W:0] sb_q[$];
  int         fire_steps[$];
  logic       last_in_fire, last_out_fire, last_in_ready;
  logic       was_stalled;
  logic [W:0] held;

  function automatic logic [W:0] model(logic [W-1:0] a, logic [W-1:0] b, logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, sample after settle, account for both handshakes.
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic ordy, input logic [W:0] exp);
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_cin    = c;
    out_ready = ordy;
    #1;
    step_no++;
    last_in_ready = in_ready;
    last_in_fire  = in_valid && in_ready;
    last_out_fire = out_valid && out_ready;
    if (was_stalled) begin
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_data", 64'({out_cout, out_sum}), 64'(held));
    end
    if (last_out_fire) begin
      fire_steps.push_back(step_no);
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got %0h expected none", {out_cout, out_sum});
      end else begin
        chk("result", 64'({out_cout, out_sum}), 64'(sb_q.pop_front()));
      end
    end
    if (last_in_fire) sb_q.push_back(exp);
    was_stalled = out_valid && !out_ready;
    held        = {out_cout, out_sum};
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, '0, '0, 1'b0, ordy, '0);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    was_stalled = 1'b0;
  endtask

  vec_t tbl[5];
  int   first, accepted, stale, guard;
  logic [W-1:0] ra, rb;
  logic         rc, rv, rr;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    was_stalled = 1'b0; held = '0;
    last_in_fire = 1'b0; last_out_fire = 1'b0; last_in_ready = 1'b0;

    tbl[0] = '{a: 16'hFFFF, b: 16'h0000, cin: 1'b1, sum: 16'h0000, cout: 1'b1};
    tbl[1] = '{a: 16'h0000, b: 16'h0000, cin: 1'b0, sum: 16'h0000, cout: 1'b0};
    tbl[2] = '{a: 16'h0001, b: 16'h0001, cin: 1'b0, sum: 16'h0002, cout: 1'b0};
    tbl[3] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, sum: 16'h0000, cout: 1'b1};
    tbl[4] = '{a: 16'h1234, b: 16'h4321, cin: 1'b0, sum: 16'h5555, cout: 1'b0};

    // Reset values
    apply_reset(2);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_sum", 64'(out_sum), 64'(0));
    chk("rst_out_cout", 64'(out_cout), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // Single-beat latency
    drive(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b1, 17'h00100);
    first = 0;
    for (int s = 1; s <= LAT + 2; s++) begin
      idle(1'b1);
      if (last_out_fire && first == 0) first = s;
    end
    chk("latency", 64'(first), 64'(LAT));

    // Back-to-back table stream
    fire_steps.delete();
    foreach (tbl[i]) drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, 1'b1, {tbl[i].cout, tbl[i].sum});
    for (int s = 0; s < LAT + 2; s++) idle(1'b1);
    chk("stream_count", 64'(fire_steps.size()), 64'(5));
    for (int i = 1; i < fire_steps.size(); i++) begin
      chk("stream_consecutive", 64'(fire_steps[i] - fire_steps[i-1]), 64'(1));
    end

    // Full pipeline with consumer stalled
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      ra = W'(i * 16'h1111);
      drive(1'b1, ra, 16'h0101, i[0], 1'b0, model(ra, 16'h0101, i[0]));
      if (last_in_fire) accepted++;
    end
    chk("stall_capacity", 64'(accepted), 64'(LAT));
    chk("stall_in_ready", 64'(last_in_ready), 64'(0));
    drive(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b1, model(16'hAAAA, 16'h5555, 1'b1));
    chk("release_in_ready", 64'(last_in_ready), 64'(1));
    chk("release_in_fire", 64'(last_in_fire), 64'(1));
    chk("release_out_fire", 64'(last_out_fire), 64'(1));
    for (int s = 0; s < 10; s++) idle(1'b1);
    chk("drain_empty", 64'(sb_q.size()), 64'(0));

    // Reset with beats in flight
    drive(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, model(16'h1111, 16'h2222, 1'b0));
    drive(1'b1, 16'h3333, 16'h4444, 1'b1, 1'b0, model(16'h3333, 16'h4444, 1'b1));
    apply_reset(1);
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    stale = 0;
    for (int s = 0; s < 6; s++) begin
      idle(1'b1);
      if (last_out_fire) stale++;
    end
    chk("midrst_no_stale", 64'(stale), 64'(0));

    // Random stream with random back-pressure
    for (int i = 0; i < 10000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      drive(rv, ra, rb, rc, rr, model(ra, rb, rc));
    end
    guard = 0;
    while (sb_q.size() != 0 && guard < 50) begin
      idle(1'b1);
      guard++;
    end
    chk("random_drain", 64'(sb_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
